// File: rtl/pc_stack_seq.sv
// Program-counter sequencer with absolute/relative jumps, branch-skip, stall,
// a hardware call/return stack and a sticky halt on completion or stack fault.
module pc_stack_seq #(
  parameter int unsigned PC_W        = 10,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic                               CLK,
  input  logic                               init,
  input  logic                               stall,
  input  logic                               done,
  input  logic                               jump_en,
  input  logic                               jump_rel,
  input  logic                               branch_en,
  input  logic                               call_en,
  input  logic                               ret_en,
  input  logic [PC_W-1:0]                    destination,
  output logic [PC_W-1:0]                    pc,
  output logic                               halt,
  output logic                               stack_err,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   sp
);

  localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [PC_W-1:0]   pc_nxt;
  logic [SP_W-1:0]   sp_nxt;
  logic              err_nxt;
  logic              push_en;
  logic [PC_W-1:0]   pc_inc;
  logic [SP_W-1:0]   sp_dec;
  logic [PC_W-1:0]   stack [STACK_DEPTH];

  assign pc_inc = pc + PC_W'(1);
  assign sp_dec = sp - SP_W'(1);
  assign halt   = (state == ST_HALT);

  always_ff @(posedge CLK or posedge init) begin
    if (init) begin
      state     <= ST_RUN;
      pc        <= PC_W'(RESET_PC);
      sp        <= '0;
      stack_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      sp        <= sp_nxt;
      stack_err <= err_nxt;
    end
  end

  // Stack storage carries no reset; only entries below sp are ever read.
  always_ff @(posedge CLK) begin
    if (push_en) begin
      stack[sp[IDX_W-1:0]] <= pc_inc;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    sp_nxt    = sp;
    err_nxt   = stack_err;
    push_en   = 1'b0;

    if (state == ST_RUN) begin
      if (done) begin
        state_nxt = ST_HALT;
      end else if (stall) begin
        pc_nxt = pc;
      end else if (ret_en) begin
        if (sp == '0) begin
          state_nxt = ST_HALT;
          err_nxt   = 1'b1;
        end else begin
          pc_nxt = stack[sp_dec[IDX_W-1:0]];
          sp_nxt = sp_dec;
        end
      end else if (call_en) begin
        if (sp == SP_W'(STACK_DEPTH)) begin
          state_nxt = ST_HALT;
          err_nxt   = 1'b1;
        end else begin
          push_en = 1'b1;
          sp_nxt  = sp + SP_W'(1);
          pc_nxt  = destination;
        end
      end else if (jump_en) begin
        // A PC_W-wide modular add is identical to sign-extend-then-truncate.
        pc_nxt = jump_rel ? (pc + destination) : destination;
      end else if (branch_en) begin
        pc_nxt = pc + PC_W'(2);
      end else begin
        pc_nxt = pc_inc;
      end
    end
  end

endmodule

// File: tb/tb_pc_stack_seq.sv
// Directed-vector bench for pc_stack_seq with hand-computed expectations.
module tb_pc_stack_seq;

  localparam int unsigned PC_W = 10;
  localparam int unsigned SD   = 4;
  localparam int unsigned SP_W = $clog2(SD + 1);

  logic            CLK = 1'b0;
  logic            init;
  logic            stall, done, jump_en, jump_rel, branch_en, call_en, ret_en;
  logic [PC_W-1:0] destination;
  logic [PC_W-1:0] pc;
  logic            halt, stack_err;
  logic [SP_W-1:0] sp;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  pc_stack_seq #(.PC_W(PC_W), .STACK_DEPTH(SD), .RESET_PC(0)) dut (
    .CLK(CLK), .init(init), .stall(stall), .done(done),
    .jump_en(jump_en), .jump_rel(jump_rel), .branch_en(branch_en),
    .call_en(call_en), .ret_en(ret_en), .destination(destination),
    .pc(pc), .halt(halt), .stack_err(stack_err), .sp(sp)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    stall = 0; done = 0; jump_en = 0; jump_rel = 0;
    branch_en = 0; call_en = 0; ret_en = 0; destination = '0;
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_reset();
    init = 1'b1;
    #1;
    init = 1'b0;
  endtask

  task automatic do_jump(input logic [PC_W-1:0] d, input logic rel);
    idle(); jump_en = 1; jump_rel = rel; destination = d; step(); idle();
  endtask

  task automatic do_call(input logic [PC_W-1:0] d);
    idle(); call_en = 1; destination = d; step(); idle();
  endtask

  task automatic do_ret();
    idle(); ret_en = 1; step(); idle();
  endtask

  task automatic check_state(input string tag, input int unsigned e_pc, input int unsigned e_sp,
                             input logic e_halt, input logic e_err);
    check({tag, ".pc"},   32'(pc),        32'(e_pc));
    check({tag, ".sp"},   32'(sp),        32'(e_sp));
    check({tag, ".halt"}, 32'(halt),      32'(e_halt));
    check({tag, ".err"},  32'(stack_err), 32'(e_err));
  endtask

  initial begin
    idle();
    init = 1'b1;
    #12;
    init = 1'b0;

    // 1: reset and increment
    check_state("reset", 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      step();
      check("incr.pc", 32'(pc), 32'(i));
    end
    check("incr.halt", 32'(halt), 0);
    check("incr.sp", 32'(sp), 0);

    // 2: jumps and branch
    do_jump(10'd100, 1'b0);
    check("jabs.pc", 32'(pc), 100);
    idle(); branch_en = 1; step(); idle();
    check("branch.pc", 32'(pc), 102);
    do_jump(10'h3FE, 1'b1);
    check("jrel.pc", 32'(pc), 100);

    // 3: nested call/return
    do_jump(10'd10, 1'b0);
    check("j10.pc", 32'(pc), 10);
    do_call(10'd200);
    check_state("call1", 200, 1, 0, 0);
    do_call(10'd300);
    check_state("call2", 300, 2, 0, 0);
    do_ret();
    check_state("ret1", 201, 1, 0, 0);
    do_ret();
    check_state("ret2", 11, 0, 0, 0);

    // 4a: overflow
    pulse_reset();
    check_state("rst4", 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      do_call(PC_W'(i * 10));
      check("ovf.fill.sp", 32'(sp), 32'(i));
    end
    check("ovf.fill.pc", 32'(pc), 40);
    do_call(10'd50);
    check_state("ovf", 40, 4, 1, 1);
    step();
    check_state("ovf.frozen", 40, 4, 1, 1);

    // 4b: underflow
    pulse_reset();
    do_ret();
    check_state("udf", 0, 0, 1, 1);
    do_jump(10'd77, 1'b0);
    check_state("udf.frozen", 0, 0, 1, 1);

    // 5: stall and done priority
    pulse_reset();
    step();
    check("pri.pc1", 32'(pc), 1);
    idle(); stall = 1; jump_en = 1; destination = 10'd50; step(); idle();
    check("stall.pc", 32'(pc), 1);
    do_call(10'd60);
    check_state("pri.call", 60, 1, 0, 0);
    idle(); done = 1; call_en = 1; destination = 10'd70; step(); idle();
    check_state("done", 60, 1, 1, 0);
    do_jump(10'd5, 1'b0);
    check_state("done.frozen", 60, 1, 1, 0);

    // 6: wrap-around
    pulse_reset();
    do_jump(10'd1023, 1'b0);
    check("w.1023", 32'(pc), 1023);
    step();
    check("wrap.incr", 32'(pc), 0);
    do_jump(10'd1022, 1'b0);
    idle(); branch_en = 1; step(); idle();
    check("wrap.branch", 32'(pc), 0);
    do_jump(10'd1023, 1'b0);
    do_call(10'd7);
    check_state("wcall", 7, 1, 0, 0);
    do_ret();
    check_state("wret", 0, 0, 0, 0);

    // 6: async reset mid-cycle while halted with sp=2
    do_call(10'd5);
    do_call(10'd6);
    idle(); done = 1; step(); idle();
    check_state("pre.async", 6, 2, 1, 0);
    #3;
    init = 1'b1;
    #1;
    check_state("async", 0, 0, 0, 0);
    init = 1'b0;
    step();
    check("post.async.pc", 32'(pc), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_stack_seq.md
Name: pc_stack_seq

Overview:
- Parametrised program-counter sequencer; successor to the single-level PC.
- Adds configurable address width, absolute and PC-relative jumps, branch-skip, stall, and a hardware call/return stack of configurable depth.
- Provides a sticky halt that is raised on program completion or on a stack fault.
- Sits between the control decoder, which supplies the enables and destination, and instruction memory, which is addressed by pc.

Parameters:
- PC_W, 10, width of pc and destination in bits.
- STACK_DEPTH, 4, number of return-address entries (≥1).
- RESET_PC, 0, pc value loaded on reset.

Ports:
- CLK  in  1  rising-edge clock
- init  in  1  asynchronous active-high reset
- stall  in  1  hold pc and stack this cycle
- done  in  1  program finished; request halt
- jump_en  in  1  take jump to target
- jump_rel  in  1  with jump_en: 1 = destination is a signed offset from pc; 0 = absolute
- branch_en  in  1  taken branch; skip next instruction
- call_en  in  1  push pc+1, then jump to absolute destination
- ret_en  in  1  pop the return address into pc
- destination  in  PC_W  absolute target or signed two's-complement offset
- pc  out  PC_W  current instruction address
- halt  out  1  sticky halt
- stack_err  out  1  sticky; set on overflow or underflow
- sp  out  $clog2(STACK_DEPTH+1)  number of valid stack entries

Behaviour:
- Reset (init=1, asynchronous, effective immediately, including mid-operation):
  - pc=RESET_PC, halt=0, stack_err=0, sp=0.
  - Stack contents are don't-care.
  - After init deasserts, updates resume on the next CLK edge.
- All updates occur on the rising edge of CLK. Each pc update takes one cycle: pc changes at the edge after the enable is sampled.
- While halt=1, pc, sp, stack contents and stack_err are frozen and all enables are ignored. Only init clears halt.
- Priority per edge, highest first (exactly one action per cycle):
  1. done=1 → halt<=1; pc unchanged.
  2. stall=1 → no change.
  3. ret_en:
     - sp==0 → halt<=1, stack_err<=1, pc unchanged.
     - else → pc<=stack[sp-1], sp<=sp-1.
  4. call_en:
     - sp==STACK_DEPTH → halt<=1, stack_err<=1, no push, pc unchanged.
     - else → stack[sp]<=pc+1, sp<=sp+1, pc<=destination (always absolute; jump_rel is ignored).
  5. jump_en:
     - jump_rel=0 → pc<=destination.
     - jump_rel=1 → pc<=pc+destination. The offset is sign-extended at PC_W and the sum is truncated to PC_W.
  6. branch_en → pc<=pc+2.
  7. Otherwise → pc<=pc+1.
- Arithmetic:
  - All pc arithmetic is modulo 2^PC_W; wrap-around is silent and is not an error.
  - pc+1 pushed by a call wraps the same way.
- Simultaneous enables resolve strictly by the priority list above. Lower-priority enables in the same cycle have no effect.
- sp stays within 0..STACK_DEPTH at all times.
- pc is combinationally the register output; no bubble cycles are inserted.

Test Plan:
1. Reset and increment:
   - Stimulus: assert init, release, run 5 idle cycles.
   - Required: pc = 0,1,2,3,4,5; halt=0; sp=0.
2. Jumps and branch:
   - Stimulus: at pc=5 jump_en abs with destination=100; then branch_en; then jump_rel with destination=10'h3FE (-2).
   - Required: pc = 100 → 102 → 100.
3. Nested call and return:
   - Stimulus: at pc=10 call to 200; at pc=200 call to 300; then ret; then ret.
   - Required: sp 0→1→2→1→0; pc 200, 300, 201, 11.
4. Overflow and underflow (STACK_DEPTH=4):
   - Overflow stimulus: 5 consecutive calls.
   - Overflow required: 5th call sets halt=1 and stack_err=1; sp=4; pc stays at the 4th target.
   - Underflow stimulus (separate run): ret with sp=0.
   - Underflow required: halt=1, stack_err=1, pc unchanged.
5. Priority and stall:
   - Stimulus: stall+jump_en.
   - Required: pc unchanged.
   - Stimulus: done+call_en in the same cycle.
   - Required: halt=1, sp unchanged, pc unchanged; later enables are ignored.
6. Wrap and async reset:
   - Stimulus: from pc=1023 increment.
   - Required: pc=0.
   - Stimulus: from pc=1022 branch.
   - Required: pc=0.
   - Stimulus: assert init mid-cycle while sp=2 and halt=1.
   - Required: pc=0, sp=0, halt=0, stack_err=0 before the next CLK edge.
